// File: rtl/sound_sequencer.sv
// -----------------------------------------------------------------------------
// sound_sequencer
//
// Arbitrates one-cycle sound-effect request pulses from the game logic onto a
// single square-wave tone generator. Each effect is a short fixed list of
// notes; every note presents a half-period reload value (tone_th) held for a
// whole number of note units. A silent gap follows every finished effect.
//
// Handshake: requests are fire-and-forget pulses. A request is latched into
// a pending bit on the edge it is seen and cleared on the edge its effect is
// granted. tone_load is a one-cycle strobe marking every change of tone_th;
// the tone generator reloads its half-period counter on that strobe.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_paddle    : request pulse, priority code 0 (lowest)
//   req_brick     : request pulse, priority code 1
//   req_score     : request pulse, priority code 2
//   req_over      : request pulse, priority code 3 (highest)
//   tone_th[19:0] : half-period in clk cycles, 0 = silence
//   tone_load     : one-cycle pulse whenever tone_th takes a new value
//   cur_snd[1:0]  : priority code of the effect playing or last played
//   busy          : high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module sound_sequencer #(
  parameter int unsigned NOTE_TICKS = 5000000,
  parameter int unsigned GAP_TICKS  = 250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_paddle,
  input  logic        req_brick,
  input  logic        req_score,
  input  logic        req_over,
  output logic [19:0] tone_th,
  output logic        tone_load,
  output logic [1:0]  cur_snd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

  typedef struct packed {
    logic [19:0] th;
    logic [2:0]  len;
    logic        last;
  } note_t;

  localparam logic [22:0] NOTE_LAST = 23'(NOTE_TICKS - 1);
  localparam logic [22:0] GAP_LAST  = 23'(GAP_TICKS - 1);

  // Note tables, indexed by {effect code, note index}.
  function automatic note_t note_lookup(input logic [1:0] snd, input logic [1:0] idx);
    note_t n;
    case ({snd, idx})
      4'b00_00: n = '{20'd31887, 3'd1, 1'b1};
      4'b01_00: n = '{20'd18961, 3'd1, 1'b0};
      4'b01_01: n = '{20'd15944, 3'd1, 1'b1};
      4'b10_00: n = '{20'd47774, 3'd1, 1'b0};
      4'b10_01: n = '{20'd37919, 3'd1, 1'b0};
      4'b10_10: n = '{20'd31887, 3'd1, 1'b0};
      4'b10_11: n = '{20'd23889, 3'd1, 1'b1};
      4'b11_00: n = '{20'd31887, 3'd2, 1'b0};
      4'b11_01: n = '{20'd37919, 3'd2, 1'b0};
      4'b11_10: n = '{20'd47774, 3'd2, 1'b0};
      4'b11_11: n = '{20'd63776, 3'd4, 1'b1};
      default:  n = '{20'd0,     3'd1, 1'b1};
    endcase
    return n;
  endfunction

  function automatic logic [1:0] highest(input logic [3:0] p);
    logic [1:0] c;
    if (p[3])      c = 2'd3;
    else if (p[2]) c = 2'd2;
    else if (p[1]) c = 2'd1;
    else           c = 2'd0;
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [19:0] tone_th_q, tone_th_d;
  logic        tone_load_q, tone_load_d;
  logic [1:0]  cur_snd_q, cur_snd_d;
  logic        busy_q, busy_d;
  logic [1:0]  idx_q, idx_d;
  logic [22:0] unit_q, unit_d;   // note-unit tick counter, reused as gap counter
  logic [2:0]  units_q, units_d; // units elapsed in the current note

  logic [3:0]  req_v;
  logic [3:0]  drop_mask;
  logic [3:0]  grant_mask;
  logic [1:0]  hi_code;
  logic        grant;
  logic        preempt;
  logic        wrap;
  logic        note_done;
  logic        eff_end;
  note_t       note_cur;
  note_t       note_nxt;
  note_t       note_first;

  always_comb begin
    state_d    = state_q;
    tone_th_d  = tone_th_q;
    cur_snd_d  = cur_snd_q;
    idx_d      = idx_q;
    unit_d     = unit_q;
    units_d    = units_q;
    grant      = 1'b0;

    req_v      = {req_over, req_score, req_brick, req_paddle};
    hi_code    = highest(pending_q);
    note_cur   = note_lookup(cur_snd_q, idx_q);
    note_nxt   = note_lookup(cur_snd_q, idx_q + 2'd1);
    note_first = note_lookup(hi_code, 2'd0);

    wrap      = (unit_q == NOTE_LAST);
    note_done = wrap && ((units_q + 3'd1) == note_cur.len);
    preempt   = (state_q == PLAY) && (|pending_q) && (hi_code > cur_snd_q);
    eff_end   = (state_q == PLAY) && !preempt && note_done && note_cur.last;

    case (state_q)
      IDLE: begin
        if (|pending_q) grant = 1'b1;
      end
      PLAY: begin
        if (preempt) begin
          grant = 1'b1;
        end else begin
          unit_d = wrap ? 23'd0 : unit_q + 23'd1;
          if (wrap) units_d = units_q + 3'd1;
          if (note_done) begin
            units_d = 3'd0;
            if (note_cur.last) begin
              state_d   = GAP;
              tone_th_d = 20'd0;
              idx_d     = 2'd0;
            end else begin
              idx_d     = idx_q + 2'd1;
              tone_th_d = note_nxt.th;
            end
          end
        end
      end
      GAP: begin
        if (unit_q == GAP_LAST) begin
          if (|pending_q) begin
            grant = 1'b1;
          end else begin
            state_d = IDLE;
            unit_d  = 23'd0;
          end
        end else begin
          unit_d = unit_q + 23'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d   = PLAY;
      cur_snd_d = hi_code;
      idx_d     = 2'd0;
      unit_d    = 23'd0;
      units_d   = 3'd0;
      tone_th_d = note_first.th;
    end

    // Repeats of the effect already playing collapse into it, except on the
    // edge it finishes, where a fresh request must survive into the gap.
    drop_mask  = (state_q == PLAY && !eff_end) ? (4'b0001 << cur_snd_q) : 4'b0000;
    grant_mask = grant ? (4'b0001 << hi_code) : 4'b0000;
    pending_d  = (pending_q | (req_v & ~drop_mask)) & ~grant_mask;

    // The strobe follows the value, so identical consecutive values
    // (e.g. OVER preempting PADDLE on 31887) produce no reload pulse.
    tone_load_d = (tone_th_d != tone_th_q);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 4'd0;
      tone_th_q   <= 20'd0;
      tone_load_q <= 1'b0;
      cur_snd_q   <= 2'd0;
      busy_q      <= 1'b0;
      idx_q       <= 2'd0;
      unit_q      <= 23'd0;
      units_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      tone_th_q   <= tone_th_d;
      tone_load_q <= tone_load_d;
      cur_snd_q   <= cur_snd_d;
      busy_q      <= busy_d;
      idx_q       <= idx_d;
      unit_q      <= unit_d;
      units_q     <= units_d;
    end
  end

  assign tone_th   = tone_th_q;
  assign tone_load = tone_load_q;
  assign cur_snd   = cur_snd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sound_sequencer
//
// Directed bench for sound_sequencer with shortened note and gap lengths.
// Every expected tone change is pushed as {edge number, tone_th, cur_snd}
// when the request is driven; a monitor pops one entry per tone_load pulse.
// Edge numbers count rising clock edges; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_sound_sequencer;

  localparam int NT = 20;
  localparam int GT = 8;
  localparam int W  = 54;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_paddle, req_brick, req_score, req_over;
  logic [19:0] tone_th;
  logic        tone_load;
  logic [1:0]  cur_snd;
  logic        busy;

  int          cyc   = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [19:0]  prev_th = 20'd0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sound_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_paddle (req_paddle),
    .req_brick  (req_brick),
    .req_score  (req_score),
    .req_over   (req_over),
    .tone_th    (tone_th),
    .tone_load  (tone_load),
    .cur_snd    (cur_snd),
    .busy       (busy)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [19:0] th, input logic [1:0] snd);
    exp_q.push_back({32'(c), th, snd});
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; the request is seen on the next rising edge,
  // whose number is returned in n.
  task automatic pulse(input logic [3:0] m, output int n);
    {req_over, req_score, req_brick, req_paddle} = m;
    n = cyc + 1;
    @(negedge clk);
    {req_over, req_score, req_brick, req_paddle} = 4'b0000;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (tone_th != prev_th) check("load_with_change", 32'(tone_load), 32'd1);
      if (tone_load) begin
        if (exp_q.size() == 0) begin
          check("expected_load_available", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("load_edge",    32'(cyc),     mon_e[53:22]);
          check("load_tone_th", 32'(tone_th), 32'(mon_e[21:2]));
          check("load_cur_snd", 32'(cur_snd), 32'(mon_e[1:0]));
        end
      end
    end
    prev_th = tone_th;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, g, p, b, o, m, k, t;
    rst_n = 1'b0;
    {req_over, req_score, req_brick, req_paddle} = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_tone_th",   32'(tone_th),   32'd0);
    check("rst_tone_load", 32'(tone_load), 32'd0);
    check("rst_cur_snd",   32'(cur_snd),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);

    // Single BRICK effect.
    pulse(4'b0010, n);
    g = n + 1;
    push(g, 20'd18961, 2'd1);
    push(g + NT, 20'd15944, 2'd1);
    push(g + 2*NT, 20'd0, 2'd1);
    check("brick_busy_before_grant", 32'(busy), 32'd0);
    wait_cyc(g);
    check("brick_busy_grant", 32'(busy), 32'd1);
    wait_cyc(g + 2*NT + GT - 1);
    check("brick_busy_gap_last", 32'(busy), 32'd1);
    wait_cyc(g + 2*NT + GT);
    check("brick_busy_idle", 32'(busy), 32'd0);
    check("brick_cur_kept",  32'(cur_snd), 32'd1);
    check("brick_queue_empty", 32'(exp_q.size()), 32'd0);

    // PADDLE and SCORE together: SCORE first, then PADDLE after the gap.
    @(negedge clk);
    pulse(4'b0101, n);
    g = n + 1;
    push(g,        20'd47774, 2'd2);
    push(g + NT,   20'd37919, 2'd2);
    push(g + 2*NT, 20'd31887, 2'd2);
    push(g + 3*NT, 20'd23889, 2'd2);
    push(g + 4*NT, 20'd0,     2'd2);
    p = g + 4*NT + GT;
    push(p,      20'd31887, 2'd0);
    push(p + NT, 20'd0,     2'd0);
    wait_cyc(g + 4*NT + 1);
    check("dual_gap_busy", 32'(busy), 32'd1);
    check("dual_gap_cur",  32'(cur_snd), 32'd2);
    wait_cyc(p + NT + GT);
    check("dual_idle_busy", 32'(busy), 32'd0);
    check("dual_idle_cur",  32'(cur_snd), 32'd0);
    check("dual_queue_empty", 32'(exp_q.size()), 32'd0);

    // OVER preempts SCORE during its second note; SCORE never resumes.
    @(negedge clk);
    pulse(4'b0100, n);
    g = n + 1;
    push(g,      20'd47774, 2'd2);
    push(g + NT, 20'd37919, 2'd2);
    k = $urandom_range(1, NT - 2);
    wait_cyc(g + NT + k - 1);
    pulse(4'b1000, m);
    o = m + 1;
    push(o,         20'd31887, 2'd3);
    push(o + 2*NT,  20'd37919, 2'd3);
    push(o + 4*NT,  20'd47774, 2'd3);
    push(o + 6*NT,  20'd63776, 2'd3);
    push(o + 10*NT, 20'd0,     2'd3);
    wait_cyc(o);
    check("over_preempt_cur",  32'(cur_snd), 32'd3);
    check("over_preempt_busy", 32'(busy), 32'd1);
    wait_cyc(o + 10*NT + GT);
    check("over_idle_busy", 32'(busy), 32'd0);
    wait_cyc(o + 10*NT + GT + 2*NT);
    check("over_no_resume", 32'(exp_q.size()), 32'd0);

    // Repeated BRICK requests while BRICK plays are all dropped.
    pulse(4'b0010, n);
    g = n + 1;
    push(g,        20'd18961, 2'd1);
    push(g + NT,   20'd15944, 2'd1);
    push(g + 2*NT, 20'd0,     2'd1);
    t = g + 2;
    while (t <= g + 2*NT - 3) begin
      wait_cyc(t - 1);
      pulse(4'b0010, m);
      t = m + $urandom_range(4, 9);
    end
    wait_cyc(g + 2*NT + GT - 1);
    check("repeat_busy_gap_last", 32'(busy), 32'd1);
    wait_cyc(g + 2*NT + GT);
    check("repeat_busy_idle", 32'(busy), 32'd0);
    wait_cyc(g + 2*NT + GT + 30);
    check("repeat_still_idle", 32'(busy), 32'd0);
    check("repeat_queue_empty", 32'(exp_q.size()), 32'd0);

    // BRICK requested during PADDLE's gap starts right at gap end.
    pulse(4'b0001, n);
    p = n + 1;
    push(p,      20'd31887, 2'd0);
    push(p + NT, 20'd0,     2'd0);
    wait_cyc(p + NT + 2);
    pulse(4'b0010, m);
    b = p + NT + GT;
    push(b,        20'd18961, 2'd1);
    push(b + NT,   20'd15944, 2'd1);
    push(b + 2*NT, 20'd0,     2'd1);
    wait_cyc(b - 1);
    check("gap_no_preempt_th", 32'(tone_th), 32'd0);
    check("gap_busy_last",     32'(busy), 32'd1);
    wait_cyc(b);
    check("gap_direct_busy", 32'(busy), 32'd1);
    wait_cyc(b + 2*NT + GT);
    check("gap_then_idle", 32'(busy), 32'd0);
    check("gap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of OVER with SCORE still pending.
    pulse(4'b1000, n);
    o = n + 1;
    push(o,        20'd31887, 2'd3);
    push(o + 2*NT, 20'd37919, 2'd3);
    wait_cyc(o + NT + 3);
    pulse(4'b0100, m);
    wait_cyc(o + NT + 10);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tone_th",   32'(tone_th), 32'd0);
    check("midrst_busy",      32'(busy), 32'd0);
    check("midrst_tone_load", 32'(tone_load), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = cyc;
    wait_cyc(k + 3*NT);
    check("post_rst_busy",    32'(busy), 32'd0);
    check("post_rst_tone_th", 32'(tone_th), 32'd0);
    check("post_rst_cur",     32'(cur_snd), 32'd0);
    check("post_rst_queue",   32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
